gpio_in_filter: RTL and testbench
=================================

Name: gpio_in_filter

Overview:
Pin-side input front end for the GPIO peripheral. It synchronises raw pad inputs, debounces them, and drives the filtered level into the GPIO block's pin-input port. It also detects edges on the filtered level and raises level-sensitive interrupt requests toward the interrupt controller. Instantiated at SoC top, between the pads and the GPIO register block.

Parameters:
NUM_IO, 2, number of input channels; legal range 1..16, since the control word has 2 bits per IO.
DB_CYCLES, 16, consecutive synchronised cycles of a new level needed before it is accepted; must be >= 1.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
io_pin_raw_i  input  NUM_IO  raw pad inputs, asynchronous to clk
reg_ctrl_i  input  32  GPIO control word; bits [2i+1:2i] = mode of IO i; 2'b10 = input
irq_mode_i  input  2*NUM_IO  per-IO edge select: 00 none, 01 rise, 10 fall, 11 both
irq_clr_i  input  NUM_IO  per-IO pending clear, single-cycle pulse
io_pin_o  output  NUM_IO  filtered level, to the GPIO block's io_pin_i
irq_pending_o  output  NUM_IO  per-IO sticky pending flags
irq_o  output  1  OR of irq_pending_o

Behaviour:
- Reset: asserts asynchronously and is released synchronously by the system. While rst is low, all flops are 0, so io_pin_o=0, irq_pending_o=0 and irq_o=0. Any debounce count in progress is discarded.
- The per-IO datapath is identical for every channel.
- Synchroniser: two flops, sync1 then sync2, reset to 0. Runs in every mode.
- en = (reg_ctrl_i[2i+1:2i] == 2'b10). en_q is en registered one clock.
- Channel disabled (en=0): stable<=0, cnt<=0, no edge events. io_pin_o[i]=0.
- Priming edge (en=1, en_q=0): stable<=sync2, cnt<=0. No edge event is generated, so enabling an IO never raises a spurious interrupt.
- Filtering (en=1, en_q=1):
  - If sync2==stable: cnt<=0.
  - Else if cnt==DB_CYCLES-1: stable<=sync2, cnt<=0, and an edge event fires on this clock.
  - Else: cnt<=cnt+1.
- cnt width is max(1, clog2(DB_CYCLES)). cnt never exceeds DB_CYCLES-1 and never wraps.
- Latency: take a pad change sampled at edge 1. io_pin_o reflects it after edge DB_CYCLES+2, provided the pad stays stable throughout.
- Glitch rejection: any return to the old level before acceptance resets cnt to 0. Output is unchanged.
- io_pin_o[i] = stable, registered.
- Edge events: rise = stable 0->1, fall = stable 1->0. An event qualifies when irq_mode_i[2i] is set for rise, or irq_mode_i[2i+1] is set for fall.
- Pending flags:
  - A qualifying event sets pending[i] on the same edge that stable updates.
  - irq_clr_i[i] clears pending[i] on the next edge.
  - Set and clear on the same edge: set wins, so no event is lost.
  - Disabling the channel does not clear pending.
- irq_o = |irq_pending_o, combinational from registered flags.
- Changing irq_mode_i mid-debounce affects only events that fire afterwards.

Decomposition:
- Shared defines header holds:
  - GPIO mode encodings: GPIO_MODE_HIZ 2'b00, GPIO_MODE_OUT 2'b01, GPIO_MODE_IN 2'b10.
  - IRQ edge encodings: NONE 00, RISE 01, FALL 10, BOTH 11.
  The GPIO register block also uses these.
- Sub-module gpio_in_chan, parameterised by DB_CYCLES: one channel covering synchroniser, enable prime, debounce counter, edge detect and pending flag. Generated NUM_IO times; the top only slices buses and forms irq_o.

Test Plan:
All scenarios use DB_CYCLES=4 and NUM_IO=2.
1. Reset: hold rst=0 while toggling pins, then release with ctrl=0 -> io_pin_o=2'b00, irq_o=0 throughout; pins toggling with ctrl=0 still give io_pin_o=0.
2. Debounce pass: ctrl=32'h2, irq_mode=4'b0001, settle 4 cycles; pin0 0->1 sampled at edge T and held -> io_pin_o[0]=1 and irq_pending_o[0]=1 exactly after edge T+5, 0 before; irq_o=1.
3. Glitch reject: pin0 high for 3 cycles, then low -> io_pin_o[0] stays 0, irq_pending_o stays 0; repeat with 4-cycle high -> accepted.
4. Enable priming: pin1=1 with ctrl[3:2]=00, irq_mode=4'b1100, then ctrl=32'h8 -> io_pin_o[1]=1 after the first enabled edge; irq_pending_o[1] stays 0.
5. Set/clear collision: pending[0]=1, irq_mode[1:0]=11; pulse irq_clr_i[0] on the same edge a falling event fires -> pending[0]=1; a later lone clear -> 0.
6. Async reset mid-debounce: pin0 rises, rst dropped after cnt=2 -> outputs 0 immediately without clk; after release with pin0=1 -> primes to 1, no interrupt.

Source files
------------

// File: rtl/gpio_in_filter_pkg.sv
// Shared encodings for the GPIO pin-input path: pad mode and interrupt edge select.
// The GPIO register block decodes the same values.
package gpio_in_filter_pkg;

  typedef enum logic [1:0] {
    GPIO_MODE_HIZ = 2'b00,
    GPIO_MODE_OUT = 2'b01,
    GPIO_MODE_IN  = 2'b10
  } gpio_mode_e;

  typedef enum logic [1:0] {
    IRQ_NONE = 2'b00,
    IRQ_RISE = 2'b01,
    IRQ_FALL = 2'b10,
    IRQ_BOTH = 2'b11
  } irq_edge_e;

  // Debounce counter width; a single-cycle filter still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_in_chan.sv
// One GPIO input channel: two-flop synchroniser, enable priming, debounce,
// edge detection and a sticky interrupt pending flag.
module gpio_in_chan
  import gpio_in_filter_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin_raw,
  input  logic [1:0] mode,
  input  logic [1:0] irq_mode,
  input  logic       irq_clr,
  output logic       pin,
  output logic       pending
);

  localparam int unsigned        CNT_W    = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             en_q;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  logic      en;
  logic      fire;
  logic      rise_sel;
  logic      fall_sel;
  logic      hit;
  irq_edge_e edge_sel;

  assign en       = (mode == GPIO_MODE_IN);
  assign edge_sel = irq_edge_e'(irq_mode);
  assign rise_sel = (edge_sel == IRQ_RISE) || (edge_sel == IRQ_BOTH);
  assign fall_sel = (edge_sel == IRQ_FALL) || (edge_sel == IRQ_BOTH);

  // Events only come from the debounce acceptance path, never from priming.
  assign fire = en && en_q && (sync2 != stable) && (cnt == CNT_LAST);
  assign hit  = fire && ((sync2 && rise_sel) || (!sync2 && fall_sel));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      en_q    <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      sync1 <= pin_raw;
      sync2 <= sync1;
      en_q  <= en;

      if (!en) begin
        stable <= 1'b0;
        cnt    <= '0;
      end else if (!en_q) begin
        stable <= sync2;
        cnt    <= '0;
      end else if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Set beats a coincident clear so an event is never dropped.
      if (hit) begin
        pending <= 1'b1;
      end else if (irq_clr) begin
        pending <= 1'b0;
      end
    end
  end

  assign pin = stable;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO pin-input front end: one filtered channel per IO plus the combined
// interrupt request to the interrupt controller.
module gpio_in_filter
  import gpio_in_filter_pkg::*;
#(
  parameter int unsigned NUM_IO    = 2,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IO-1:0]   io_pin_raw_i,
  input  logic [31:0]         reg_ctrl_i,
  input  logic [2*NUM_IO-1:0] irq_mode_i,
  input  logic [NUM_IO-1:0]   irq_clr_i,
  output logic [NUM_IO-1:0]   io_pin_o,
  output logic [NUM_IO-1:0]   irq_pending_o,
  output logic                irq_o
);

  for (genvar i = 0; i < NUM_IO; i++) begin : g_chan
    gpio_in_chan #(
      .DB_CYCLES(DB_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .pin_raw (io_pin_raw_i[i]),
      .mode    (reg_ctrl_i[2*i+1:2*i]),
      .irq_mode(irq_mode_i[2*i+1:2*i]),
      .irq_clr (irq_clr_i[i]),
      .pin     (io_pin_o[i]),
      .pending (irq_pending_o[i])
    );
  end

  // Mode fields above NUM_IO belong to IOs this instance does not have.
  if (NUM_IO < 16) begin : g_unused
    logic unused_ctrl;
    assign unused_ctrl = ^reg_ctrl_i[31:2*NUM_IO];
  end

  assign irq_o = |irq_pending_o;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Scoreboard bench for gpio_in_filter with NUM_IO=2, DB_CYCLES=4.
module tb_gpio_in_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  io_pin_raw_i;
  logic [31:0] reg_ctrl_i;
  logic [3:0]  irq_mode_i;
  logic [1:0]  irq_clr_i;
  logic [1:0]  io_pin_o;
  logic [1:0]  irq_pending_o;
  logic        irq_o;

  gpio_in_filter #(
    .NUM_IO   (2),
    .DB_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io_pin_raw_i (io_pin_raw_i),
    .reg_ctrl_i   (reg_ctrl_i),
    .irq_mode_i   (irq_mode_i),
    .irq_clr_i    (irq_clr_i),
    .io_pin_o     (io_pin_o),
    .irq_pending_o(irq_pending_o),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [1:0] pin;
    logic [1:0] pend;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [1:0] pin, logic [1:0] pend);
    logic irq_exp;
    irq_exp = |pend;
    total++;
    if (io_pin_o === pin && irq_pending_o === pend && irq_o === irq_exp) begin
      passed++;
    end else begin
      $display("FAIL %s @cyc %0d: got pin=%b pend=%b irq=%b, want pin=%b pend=%b irq=%b",
               nm, cyc, io_pin_o, irq_pending_o, irq_o, pin, pend, irq_exp);
    end
  endfunction

  // Queue an expectation for the negedge that follows posedge number cyc+dc.
  function automatic void exp(int dc, logic [1:0] pin, logic [1:0] pend, string nm);
    exp_t e;
    e.c = cyc + dc; e.pin = pin; e.pend = pend; e.nm = nm;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      if (e.c < cyc) begin
        total++;
        $display("FAIL %s: expectation for cyc %0d not sampled, now cyc %0d", e.nm, e.c, cyc);
      end else begin
        check(e.nm, e.pin, e.pend);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, queue depth %0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    io_pin_raw_i = 2'b00;
    reg_ctrl_i   = 32'h0;
    irq_mode_i   = 4'b0000;
    irq_clr_i    = 2'b00;

    // 1: reset holds everything at 0, then disabled channels stay 0
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      io_pin_raw_i = 2'(i);
      exp(1, 2'b00, 2'b00, "rst_hold");
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      io_pin_raw_i = 2'(i + 1);
      exp(1, 2'b00, 2'b00, "ctrl_off");
      @(negedge clk);
    end

    // 2: sustained rise on pin0 accepted after edge T+5
    io_pin_raw_i = 2'b00;
    reg_ctrl_i   = 32'h2;
    irq_mode_i   = 4'b0001;
    tick(4);
    io_pin_raw_i = 2'b01;
    exp(4, 2'b00, 2'b00, "db_early");
    exp(5, 2'b00, 2'b00, "db_pre");
    exp(6, 2'b01, 2'b01, "db_post");
    tick(8);
    irq_clr_i = 2'b01;
    exp(1, 2'b01, 2'b00, "clr");
    tick(1);
    irq_clr_i = 2'b00;

    // 3: falling edge without fall select, 3-cycle glitch, 4-cycle pulse
    io_pin_raw_i = 2'b00;
    exp(6, 2'b00, 2'b00, "fall_no_irq");
    tick(8);
    io_pin_raw_i = 2'b01;
    tick(3);
    io_pin_raw_i = 2'b00;
    exp(3, 2'b00, 2'b00, "glitch3");
    exp(5, 2'b00, 2'b00, "glitch3_late");
    tick(8);
    io_pin_raw_i = 2'b01;
    exp(5, 2'b00, 2'b00, "acc4_pre");
    exp(6, 2'b01, 2'b01, "acc4_post");
    tick(4);
    io_pin_raw_i = 2'b00;
    exp(6, 2'b00, 2'b01, "acc4_fall");
    tick(8);
    irq_clr_i = 2'b01;
    exp(1, 2'b00, 2'b00, "clr2");
    tick(1);
    irq_clr_i = 2'b00;
    tick(1);

    // 4: enabling IO1 with its pad already high primes without an event
    io_pin_raw_i = 2'b10;
    irq_mode_i   = 4'b1100;
    tick(4);
    exp(1, 2'b00, 2'b00, "ch1_off");
    tick(2);
    reg_ctrl_i = 32'hA;
    exp(1, 2'b10, 2'b00, "prime");
    exp(4, 2'b10, 2'b00, "prime_hold");
    tick(6);

    // 5: clear coinciding with a fall event loses to the set
    irq_mode_i   = 4'b1111;
    io_pin_raw_i = 2'b11;
    exp(6, 2'b11, 2'b01, "rise_both");
    tick(10);
    io_pin_raw_i = 2'b10;
    tick(5);
    irq_clr_i = 2'b01;
    exp(1, 2'b10, 2'b01, "collide");
    tick(1);
    irq_clr_i = 2'b00;
    exp(3, 2'b10, 2'b01, "collide_hold");
    tick(4);
    irq_clr_i = 2'b01;
    exp(1, 2'b10, 2'b00, "lone_clr");
    tick(1);
    irq_clr_i = 2'b00;
    tick(2);

    // 6: asynchronous reset in the middle of a debounce
    io_pin_raw_i = 2'b11;
    tick(4);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 2'b00, 2'b00);
    exp(1, 2'b00, 2'b00, "rst_low");
    @(negedge clk);
    rst        = 1'b1;
    reg_ctrl_i = 32'h0;
    exp(1, 2'b00, 2'b00, "post_rel");
    tick(3);
    reg_ctrl_i = 32'hA;
    exp(1, 2'b11, 2'b00, "reprime");
    exp(6, 2'b11, 2'b00, "reprime_hold");
    tick(8);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
